apb_completer_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_timeout_ctr.sv | 40 ++++
 rtl/apb_completer_bridge.sv | 156 +++++++++++++++
 tb/tb_apb_completer_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the APB completer bridge
//
// Contents:
//   APB_ADDR_WIDTH / APB_DATA_WIDTH : default bus widths
//   apb_state_e                     : bridge FSM states
//   apb_xfer_t                      : one latched transfer (we, addr, wdata)
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                      we;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_xfer_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - saturating wait-cycle counter with expiry flag
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_clr      clear the count to zero (has priority over i_en)
//   i_en       count this cycle
//   o_expired  high in the enabled cycle whose increment brings the count to TIMEOUT
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int                 CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]      CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Count sticks at TIMEOUT so a stuck enable can never wrap back to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Flag the edge at which the count reaches TIMEOUT, so the owner can act on
  // that same edge: with TIMEOUT=N the enable is seen for exactly N cycles.
  assign o_expired = i_en && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/apb_completer_bridge.sv
// rtl/apb_completer_bridge.sv - APB completer to single-outstanding req/ack register bus
//
// Ports:
//   i_clk, i_rst_n                    clock (rising edge), asynchronous active-low reset
//   i_psel, i_penable, i_pwrite       APB control
//   i_paddr, i_pwdata                 APB address / write data
//   o_prdata, o_pready, o_pslverr     APB completion (all registered)
//   o_req, o_we, o_addr, o_wdata      downstream request, held until ack or timeout
//   i_rdata, i_ack, i_err             downstream response, valid with the one-cycle ack
module apb_completer_bridge
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = APB_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 8'hC0,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr,
  output logic                  o_req,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_ack,
  input  logic                  i_err
);

  apb_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  // Set once the master has been seen to drop psel during REQ; the downstream
  // side still finishes, but nobody is waiting for the APB completion.
  logic                  r_drop;

  logic w_setup;
  logic w_in_range;
  logic w_tmo;
  logic w_ctr_en;
  logic w_ctr_clr;

  assign w_setup    = i_psel && !i_penable;
  assign w_in_range = (i_paddr < ADDR_LIMIT);
  assign w_ctr_en   = (r_state == ST_REQ);
  assign w_ctr_clr  = (r_state != ST_REQ);

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_ctr_clr),
    .i_en      (w_ctr_en),
    .o_expired (w_tmo)
  );

  // IDLE -> REQ/ERR on the setup edge; REQ and ERR each end by loading the
  // one-cycle pready pulse and moving to RESP, which clears it on the way back
  // to IDLE. This gives the fixed one-wait-state minimum latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_drop    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (w_setup) begin
            r_we    <= i_pwrite;
            r_addr  <= i_paddr;
            r_wdata <= i_pwdata;
            r_drop  <= 1'b0;
            if (w_in_range) begin
              r_req   <= 1'b1;
              r_state <= ST_REQ;
            end else begin
              r_state <= ST_ERR;
            end
          end
        end

        ST_REQ: begin
          // ack is tested first so an ack on the expiry edge still wins.
          if (i_ack || w_tmo) begin
            r_req <= 1'b0;
            if (i_ack && !r_we) begin
              r_prdata <= i_rdata;
            end
            if (r_drop || !i_psel) begin
              r_state <= ST_IDLE;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= i_ack ? i_err : 1'b1;
              r_state   <= ST_RESP;
            end
          end else if (!i_psel) begin
            r_drop <= 1'b1;
          end
        end

        ST_ERR: begin
          if (i_psel) begin
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RESP: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_req     <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_prdata  = r_prdata;
  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;
  assign o_req     = r_req;
  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;

endmodule

// File: tb/tb_apb_completer_bridge.sv
// tb/tb_apb_completer_bridge.sv - scoreboard bench for apb_completer_bridge
module tb_apb_completer_bridge;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  apb_completer_bridge #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .ADDR_LIMIT (8'hC0),
    .TIMEOUT    (TMO)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwrite  (pwrite),
    .i_paddr   (paddr),
    .i_pwdata  (pwdata),
    .o_prdata  (prdata),
    .o_pready  (pready),
    .o_pslverr (pslverr),
    .o_req     (req),
    .o_we      (we),
    .o_addr    (addr),
    .o_wdata   (wdata),
    .i_rdata   (rdata),
    .i_ack     (ack),
    .i_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  typedef struct {
    logic [31:0] prdata;
    logic        pslverr;
    int          cyc;
  } rsp_t;

  typedef struct {
    apb_xfer_t x;
    int        dur;   // 0: do not check how long req stays high
    int        cyc;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];

  logic [31:0] model_prdata = 32'h0;

  // Downstream responder configuration
  int          ds_wait   = 0;
  logic        ds_ack_en = 1'b0;
  logic [31:0] ds_rdata  = 32'h0;
  logic        ds_err    = 1'b0;
  logic        ds_force  = 1'b0;

  initial begin
    int req_cnt;
    req_cnt = 0;
    ack = 1'b0; err = 1'b0; rdata = 32'h0;
    forever begin
      @(negedge clk);
      if ((req && ds_ack_en && req_cnt == ds_wait) || ds_force) begin
        ack = 1'b1; err = ds_err; rdata = ds_rdata;
      end else begin
        ack = 1'b0; err = 1'b0;
      end
      req_cnt = req ? req_cnt + 1 : 0;
    end
  end

  // APB completion monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (pready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_pready", 32'(pready), 32'h0);
        end else begin
          e = rsp_q.pop_front();
          check("pready_cycle", 32'(cyc), 32'(e.cyc));
          check("prdata", prdata, e.prdata);
          check("pslverr", 32'(pslverr), 32'(e.pslverr));
        end
      end else if (pslverr) begin
        check("pslverr_without_pready", 32'(pslverr), 32'h0);
      end
    end
  end

  // Downstream request monitor
  initial begin
    req_t cur;
    int   rise_c;
    logic prev;
    cur.dur = 0; cur.cyc = 0; cur.x = '0;
    rise_c = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req && !prev) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'(req), 32'h0);
          cur.dur = 0;
        end else begin
          cur = req_q.pop_front();
          check("req_cycle", 32'(cyc), 32'(cur.cyc));
          check("req_we", 32'(we), 32'(cur.x.we));
          check("req_addr", 32'(addr), 32'(cur.x.addr));
          check("req_wdata", wdata, cur.x.wdata);
        end
        rise_c = cyc;
      end
      if (!req && prev && cur.dur != 0) begin
        check("req_duration", 32'(cyc - rise_c), 32'(cur.dur));
      end
      prev = req;
    end
  end

  // One APB transfer; k = downstream wait cycles before ack (ack_en=0: never ack)
  task automatic apb_do(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input int k, input logic ack_en, input logic [31:0] rd, input logic e);
    int   c0;
    int   n;
    rsp_t r;
    req_t q;
    ds_wait = k; ds_ack_en = ack_en; ds_rdata = rd; ds_err = e;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    c0 = cyc;
    if (a < 8'hC0) begin
      q.x.we = wr; q.x.addr = a; q.x.wdata = d;
      q.dur = ack_en ? k + 1 : TMO;
      q.cyc = c0 + 1;
      req_q.push_back(q);
      if (ack_en && !wr) model_prdata = rd;
      r.prdata  = model_prdata;
      r.pslverr = ack_en ? e : 1'b1;
      r.cyc     = c0 + 2 + (ack_en ? k : TMO - 1);
    end else begin
      r.prdata  = model_prdata;
      r.pslverr = 1'b1;
      r.cyc     = c0 + 2;
    end
    rsp_q.push_back(r);
    @(negedge clk);
    penable = 1'b1;
    n = 0;
    while (!pready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!pready) check("pready_timeout", 32'(pready), 32'h1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int   c0;
    req_t q;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0;
    #12;
    check("rst_req", 32'(req), 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_wdata", wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    apb_do(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b1, 32'hFFFF_0000, 1'b0);
    apb_do(1'b0, 8'h20, 32'h0000_0020, 3, 1'b1, 32'h12345678, 1'b0);
    apb_do(1'b0, 8'hC4, 32'h0, 0, 1'b1, 32'h5555_5555, 1'b0);
    apb_do(1'b1, 8'h04, 32'h0404_0404, 0, 1'b0, 32'h0, 1'b0);

    // late ack after the timeout completion must be ignored
    @(posedge clk); #1 ds_force = 1'b1;
    @(posedge clk); #1 ds_force = 1'b0;
    repeat (3) @(negedge clk);

    apb_do(1'b0, 8'h08, 32'h0, 1, 1'b1, 32'hA5A5_0008, 1'b1);
    apb_do(1'b0, 8'hBF, 32'h0, 0, 1'b1, 32'h0BF0_0BF0, 1'b0);
    apb_do(1'b0, 8'hC0, 32'h0, 0, 1'b1, 32'h0, 1'b0);
    // ack lands on the same edge the timeout expires: ack wins
    apb_do(1'b0, 8'h3C, 32'h0, TMO - 1, 1'b1, 32'h7777_3C3C, 1'b0);

    // psel dropped while req is pending: downstream completes, no pready
    ds_wait = 2; ds_ack_en = 1'b1; ds_rdata = 32'h0; ds_err = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'h1414_1414;
    c0 = cyc;
    q.x.we = 1'b1; q.x.addr = 8'h14; q.x.wdata = 32'h1414_1414; q.dur = 3; q.cyc = c0 + 1;
    req_q.push_back(q);
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    repeat (6) @(negedge clk);

    // asynchronous reset while a read is waiting for ack
    ds_ack_en = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h30; pwdata = 32'h0;
    c0 = cyc;
    q.x.we = 1'b0; q.x.addr = 8'h30; q.x.wdata = 32'h0; q.dur = 0; q.cyc = c0 + 1;
    req_q.push_back(q);
    @(negedge clk); penable = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(req), 32'h0);
    check("async_rst_pready", 32'(pready), 32'h0);
    check("async_rst_pslverr", 32'(pslverr), 32'h0);
    check("async_rst_prdata", prdata, 32'h0);
    model_prdata = 32'h0;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    apb_do(1'b1, 8'h00, 32'h0000_CAFE, 0, 1'b1, 32'h0, 1'b0);

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    check("req_queue_drained", 32'(req_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
